// File: rtl/ps2_scan_rx_pkg.sv
// rtl/ps2_scan_rx_pkg.sv - shared PS/2 receiver types and constants
// Purpose: prefix byte values, frame-state enum, event record and parity helper
//          shared by the PS/2 scan-code receiver, its event FIFO and interface.
// Ports:   none (package).
package ps2_pkg;

  localparam int          PS2_CODE_W  = 8;
  localparam logic [7:0]  PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// rtl/ps2_scan_rx_if.sv - key-event stream handshake between receiver and consumer
// Purpose: groups the event stream (valid/ready plus payload) into one bundle.
// Ports:   evt_valid  head event present (receiver -> consumer)
//          evt_ready  consumer pops head when evt_valid & evt_ready
//          evt_code   scan code of head event
//          evt_ext    head event was preceded by E0
//          evt_brk    head event was preceded by F0 (release)
interface ps2_scan_rx_if;
  import ps2_pkg::*;

  logic                  evt_valid;
  logic                  evt_ready;
  logic [PS2_CODE_W-1:0] evt_code;
  logic                  evt_ext;
  logic                  evt_brk;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_brk,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_brk,
    output evt_ready
  );

endinterface

// File: rtl/ps2_scan_rx_evt_fifo.sv
// rtl/ps2_scan_rx_evt_fifo.sv - first-word-fall-through event FIFO
// Purpose: small FWFT FIFO holding decoded key events; head data is presented
//          whenever head_valid is high and held until popped.
// Ports:   clk, resetn    clock, synchronous active-low reset
//          push/push_data write side; a push while full without a pop is dropped
//          pop            pop request, ignored when empty
//          head_valid/head_data  current head entry (zero when empty)
//          count          entries held
//          overflow       one-cycle pulse when a push is dropped
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;

  assign head_valid = ~empty;
  assign head_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 device-to-host scan-code receiver with event FIFO
// Purpose: synchronises PS2_CLK/PS2_DAT, frames 11-bit PS/2 words, checks odd
//          parity and stop bit, abandons stalled frames, folds E0/F0 prefixes
//          into event flags (unless RAW_MODE) and queues events in a FWFT FIFO.
// Ports:   CLOCK_50, Resetn  system clock, synchronous active-low reset
//          PS2_CLK, PS2_DAT  asynchronous device lines (receive only)
//          evt               event stream (valid/ready/code/ext/brk)
//          fifo_count        entries held in the event FIFO
//          err_flags         sticky {overflow, frame_err, parity_err}
//          err_clr           one-cycle pulse clears err_flags (a new error wins)
// FIFO_DEPTH must be a power of two in 2..64.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int RAW_MODE    = 0
) (
  input  logic                        CLOCK_50,
  input  logic                        Resetn,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DAT,
  ps2_scan_rx_if.master               evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  err_flags,
  input  logic                        err_clr
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;

  ps2_state_t state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [WD_W-1:0] wd_cnt;
  logic            ext_pend;
  logic            brk_pend;
  logic            push_q;
  ps2_evt_t        push_evt;

  logic     timeout_now;
  logic     frame_err_now;
  logic     parity_err_now;
  logic     byte_ok;
  logic     fifo_ovf;
  ps2_evt_t head;

  // Idle PS/2 bus is high, so the synchronisers reset to 1 to avoid a bogus edge.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  // Watchdog fires one cycle before the count would reach TIMEOUT_CYC, i.e. on
  // the TIMEOUT_CYC-th idle cycle; a fall in that cycle rescues the frame.
  assign timeout_now    = (state != IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign frame_err_now  = ((state == STOP) && fall && !dat_s2) || timeout_now;
  assign parity_err_now = (state == STOP) && fall && dat_s2 && !ps2_parity_ok(shift_q, par_q);
  assign byte_ok        = (state == STOP) && fall && dat_s2 &&  ps2_parity_ok(shift_q, par_q);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      wd_cnt   <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      push_q   <= 1'b0;
      push_evt <= '0;
    end else begin
      push_q <= 1'b0;

      if (state == IDLE || fall) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 1'b1;

      if (timeout_now) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift_q <= {dat_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_q <= dat_s2;
            state <= STOP;
          end
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A corrupted frame may have been the real key byte, so stale prefixes
      // must not attach to whatever arrives next.
      if (frame_err_now || parity_err_now) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        if (RAW_MODE != 0) begin
          push_q   <= 1'b1;
          push_evt <= '{code: shift_q, ext: 1'b0, brk: 1'b0};
        end else if (shift_q == PS2_PFX_EXT) begin
          ext_pend <= 1'b1;
        end else if (shift_q == PS2_PFX_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          push_q   <= 1'b1;
          push_evt <= '{code: shift_q, ext: ext_pend, brk: brk_pend};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) err_flags <= 3'b000;
    else         err_flags <= (err_flags & ~{3{err_clr}}) |
                              {fifo_ovf, frame_err_now, parity_err_now};
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk        (CLOCK_50),
    .resetn     (Resetn),
    .push       (push_q),
    .push_data  (push_evt),
    .pop        (evt.evt_ready),
    .head_valid (evt.evt_valid),
    .head_data  (head),
    .count      (fifo_count),
    .overflow   (fifo_ovf)
  );

  assign evt.evt_code = head.code;
  assign evt.evt_ext  = head.ext;
  assign evt.evt_brk  = head.brk;

endmodule
